fpu_issue_ctrl: RTL and testbench

//  Upstream issue/decode stage for the combinational single-precision FPU. Decodes RISC-V OP-FP
//  (opcode 1010011) instructions into the FPU 5-bit sel code and drives its A/B operands.

---
 rtl/fpu_issue_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_fpu_issue_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : fpu_issue_ctrl
// Brief   : OP-FP decode/issue stage for a combinational single-precision FPU.
//           Holds operands for LATENCY cycles, captures the result and hands it
//           to writeback over valid/ready. FPU_SGNJ_EN adds local FSGNJ* ops.
// Revision: 1.0 - initial release
// ============================================================================
module fpu_issue_ctrl #(
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [31:0] instr,
    input  logic [31:0] rs1_int,
    input  logic [31:0] frs1,
    input  logic [31:0] frs2,
    output logic [31:0] fpu_a,
    output logic [31:0] fpu_b,
    output logic [4:0]  fpu_sel,
    input  logic [31:0] fpu_res,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] result_o,
    output logic [4:0]  rd_o,
    output logic        wb_fp_o,
    output logic        illegal_o
);
    localparam logic [1:0]       S_IDLE    = 2'd0;
    localparam logic [1:0]       S_EXEC    = 2'd1;
    localparam logic [1:0]       S_DONE    = 2'd2;
    localparam logic [6:0]       OPC_OP_FP = 7'b1010011;
    localparam int               CNT_W     = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(LATENCY - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      fpu_a_q, fpu_b_q, result_q;
    logic [4:0]       fpu_sel_q, rd_q;
    logic             wb_fp_q, illegal_q;

    logic [6:0]       w_funct7;
    logic [2:0]       w_rm;
    logic [4:0]       w_rs2;
    logic             w_dec_legal, w_dec_wb_fp, w_dec_a_int, w_dec_sgnj;
    logic [4:0]       w_dec_sel;
    logic             w_accept, w_exec_last;
    logic [31:0]      w_res_mux;
    logic             w_unused_bits;

    assign w_funct7      = instr[31:25];
    assign w_rm          = instr[14:12];
    assign w_rs2         = instr[24:20];
    assign w_unused_bits = ^instr[19:15];

    always_comb begin
        w_dec_legal = 1'b1;
        w_dec_sel   = 5'd0;
        w_dec_wb_fp = 1'b1;
        w_dec_a_int = 1'b0;
        w_dec_sgnj  = 1'b0;
        if (instr[6:0] != OPC_OP_FP) begin
            w_dec_legal = 1'b0;
        end else begin
            case (w_funct7)
                7'b0000000: w_dec_sel = 5'd4;
                7'b0000100: w_dec_sel = 5'd5;
                7'b0001000: w_dec_sel = 5'd6;
                7'b0010100: begin
                    if (w_rm == 3'b000)      w_dec_sel   = 5'd7;
                    else if (w_rm == 3'b001) w_dec_sel   = 5'd8;
                    else                     w_dec_legal = 1'b0;
                end
                7'b1010000: begin
                    w_dec_wb_fp = 1'b0;
                    if (w_rm == 3'b010)      w_dec_sel   = 5'd9;
                    else if (w_rm == 3'b001) w_dec_sel   = 5'd10;
                    else if (w_rm == 3'b000) w_dec_sel   = 5'd11;
                    else                     w_dec_legal = 1'b0;
                end
                7'b1110000: begin
                    w_dec_sel   = 5'd12;
                    w_dec_wb_fp = 1'b0;
                    w_dec_legal = (w_rm == 3'b000) && (w_rs2 == 5'd0);
                end
                7'b1111000: begin
                    w_dec_sel   = 5'd13;
                    w_dec_a_int = 1'b1;
                    w_dec_legal = (w_rs2 == 5'd0);
                end
                7'b1101000: begin
                    w_dec_sel   = 5'd14;
                    w_dec_a_int = 1'b1;
                    w_dec_legal = (w_rs2 == 5'd0);
                end
                7'b1100000: begin
                    w_dec_sel   = 5'd15;
                    w_dec_wb_fp = 1'b0;
                    w_dec_legal = (w_rs2 == 5'd0);
                end
`ifdef FPU_SGNJ_EN
                7'b0010000: begin
                    w_dec_sgnj  = 1'b1;
                    w_dec_legal = (w_rm <= 3'b010);
                end
`endif
                default: w_dec_legal = 1'b0;
            endcase
        end
    end

    assign w_accept    = valid_i && ready_o && !flush;
    assign w_exec_last = (state_q == S_EXEC) && (cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_accept && w_dec_legal) begin
                        state_d = S_EXEC;
                        cnt_d   = '0;
                    end
                end
                S_EXEC: begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_DONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_DONE:  if (ready_i) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        ready_o   = (state_q == S_IDLE);
        valid_o   = (state_q == S_DONE);
        fpu_a     = fpu_a_q;
        fpu_b     = fpu_b_q;
        fpu_sel   = fpu_sel_q;
        result_o  = result_q;
        rd_o      = rd_q;
        wb_fp_o   = wb_fp_q;
        illegal_o = illegal_q;
    end

`ifdef FPU_SGNJ_EN
    logic       sgnj_q;
    logic [1:0] sgnj_kind_q;
    logic       w_sgn;

    // Sign-injection needs only the held operands, so it bypasses the FPU.
    always_comb begin
        case (sgnj_kind_q)
            2'b00:   w_sgn = fpu_b_q[31];
            2'b01:   w_sgn = ~fpu_b_q[31];
            default: w_sgn = fpu_a_q[31] ^ fpu_b_q[31];
        endcase
        w_res_mux = sgnj_q ? {w_sgn, fpu_a_q[30:0]} : fpu_res;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sgnj_q      <= 1'b0;
            sgnj_kind_q <= 2'b00;
        end else if (w_accept && w_dec_legal) begin
            sgnj_q      <= w_dec_sgnj;
            sgnj_kind_q <= w_rm[1:0];
        end
    end
`else
    logic w_unused_sgnj;
    assign w_unused_sgnj = w_dec_sgnj;
    assign w_res_mux     = fpu_res;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            fpu_a_q   <= '0;
            fpu_b_q   <= '0;
            fpu_sel_q <= '0;
            rd_q      <= '0;
            wb_fp_q   <= 1'b0;
            illegal_q <= 1'b0;
            result_q  <= '0;
        end else begin
            illegal_q <= w_accept && !w_dec_legal;
            if (w_accept && w_dec_legal) begin
                fpu_a_q   <= w_dec_a_int ? rs1_int : frs1;
                fpu_b_q   <= frs2;
                fpu_sel_q <= w_dec_sel;
                rd_q      <= instr[11:7];
                wb_fp_q   <= w_dec_wb_fp;
            end
            if (w_exec_last && !flush) result_q <= w_res_mux;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_fpu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_fpu_issue_ctrl
// Brief   : Scoreboard bench for fpu_issue_ctrl with a stub combinational FPU.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fpu_issue_ctrl;
    localparam int LATENCY = 2;

    logic        clk;
    logic        rst, flush, valid_i, ready_o, ready_i;
    logic [31:0] instr, rs1_int, frs1, frs2;
    logic [31:0] fpu_a, fpu_b, fpu_res, result_o;
    logic [4:0]  fpu_sel, rd_o;
    logic        valid_o, wb_fp_o, illegal_o;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        wb_fp;
    } exp_t;
    exp_t sb_q[$];

    fpu_issue_ctrl #(.LATENCY(LATENCY)) dut (
        .clk(clk), .rst(rst), .flush(flush), .valid_i(valid_i), .ready_o(ready_o),
        .instr(instr), .rs1_int(rs1_int), .frs1(frs1), .frs2(frs2),
        .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_sel(fpu_sel), .fpu_res(fpu_res),
        .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o), .rd_o(rd_o),
        .wb_fp_o(wb_fp_o), .illegal_o(illegal_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in FPU: exact values for the documented vectors, a mixing hash otherwise.
    function automatic logic [31:0] fpu_stub(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b);
        if (sel == 5'd4 && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
        if (sel == 5'd10 && a == 32'h3F800000 && b == 32'h40000000) return 32'h00000001;
        if (sel == 5'd14 && a == 32'd5) return 32'h40A00000;
        return a ^ {b[15:0], b[31:16]} ^ {27'd0, sel} ^ 32'h5A5A0000;
    endfunction

    always_comb fpu_res = fpu_stub(fpu_sel, fpu_a, fpu_b);

    function automatic logic [31:0] mk(input logic [6:0] f7, input logic [4:0] rs2, input logic [2:0] rm, input logic [4:0] rd);
        return {f7, rs2, 5'd3, rm, rd, 7'b1010011};
    endfunction

    function automatic void model_decode(input logic [31:0] ins, input logic [31:0] rs1v,
                                         input logic [31:0] f1, input logic [31:0] f2,
                                         output logic legal, output logic [4:0] sel,
                                         output logic [31:0] a, output logic [31:0] b,
                                         output logic [31:0] res, output logic wb);
        logic [6:0] f7;
        logic [2:0] rm;
        logic [4:0] rs2;
        logic       sg;
        f7 = ins[31:25]; rm = ins[14:12]; rs2 = ins[24:20];
        legal = 1'b0; sel = 5'd0; a = f1; b = f2; wb = 1'b1; sg = 1'b0;
        if (ins[6:0] == 7'b1010011) begin
            if (f7 == 7'h00)                          begin legal = 1; sel = 4; end
            else if (f7 == 7'h04)                     begin legal = 1; sel = 5; end
            else if (f7 == 7'h08)                     begin legal = 1; sel = 6; end
            else if (f7 == 7'h14 && rm == 0)          begin legal = 1; sel = 7; end
            else if (f7 == 7'h14 && rm == 1)          begin legal = 1; sel = 8; end
            else if (f7 == 7'h50 && rm == 2)          begin legal = 1; sel = 9;  wb = 0; end
            else if (f7 == 7'h50 && rm == 1)          begin legal = 1; sel = 10; wb = 0; end
            else if (f7 == 7'h50 && rm == 0)          begin legal = 1; sel = 11; wb = 0; end
            else if (f7 == 7'h70 && rm == 0 && rs2 == 0) begin legal = 1; sel = 12; wb = 0; end
            else if (f7 == 7'h78 && rs2 == 0)         begin legal = 1; sel = 13; a = rs1v; end
            else if (f7 == 7'h68 && rs2 == 0)         begin legal = 1; sel = 14; a = rs1v; end
            else if (f7 == 7'h60 && rs2 == 0)         begin legal = 1; sel = 15; wb = 0; end
`ifdef FPU_SGNJ_EN
            else if (f7 == 7'h10 && rm <= 2)          begin legal = 1; sel = 0; sg = 1; end
`endif
        end
        if (sg) begin
            if (rm == 0)      res = {f2[31], f1[30:0]};
            else if (rm == 1) res = {~f2[31], f1[30:0]};
            else              res = {f1[31] ^ f2[31], f1[30:0]};
        end else begin
            res = fpu_stub(sel, a, b);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string tag, input logic [31:0] ins, input logic [31:0] rs1v,
                          input logic [31:0] f1, input logic [31:0] f2, input int hold);
        logic        legal, wb;
        logic [4:0]  sel;
        logic [31:0] ea, eb, eres, prev;
        exp_t        e;
        int          n;
        model_decode(ins, rs1v, f1, f2, legal, sel, ea, eb, eres, wb);
        n = 0;
        while (!ready_o && n < 20) begin tick(); n++; end
        instr = ins; rs1_int = rs1v; frs1 = f1; frs2 = f2; valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        instr = $urandom(); rs1_int = $urandom(); frs1 = $urandom(); frs2 = $urandom();
        if (!legal) begin
            checks++;
            if (illegal_o !== 1'b1 || valid_o !== 1'b0 || ready_o !== 1'b1) begin
                errors++;
                $display("FAIL %s illegal: got illegal=%0b valid=%0b ready=%0b exp 1/0/1", tag, illegal_o, valid_o, ready_o);
            end
            tick();
            checks++;
            if (illegal_o !== 1'b0 || valid_o !== 1'b0) begin
                errors++;
                $display("FAIL %s illegal pulse width: got illegal=%0b valid=%0b exp 0/0", tag, illegal_o, valid_o);
            end
            return;
        end
        sb_q.push_back('{res: eres, rd: ins[11:7], wb_fp: wb});
        checks++;
        if (fpu_a !== ea || fpu_b !== eb || fpu_sel !== sel || ready_o !== 1'b0 || illegal_o !== 1'b0) begin
            errors++;
            $display("FAIL %s issue: got a=%h b=%h sel=%0d ready=%0b ill=%0b exp a=%h b=%h sel=%0d ready=0 ill=0",
                     tag, fpu_a, fpu_b, fpu_sel, ready_o, illegal_o, ea, eb, sel);
        end
        n = 1;
        while (!valid_o && n < 20) begin
            checks++;
            if (fpu_a !== ea || fpu_b !== eb || fpu_sel !== sel) begin
                errors++;
                $display("FAIL %s operand hold: got a=%h b=%h sel=%0d exp a=%h b=%h sel=%0d", tag, fpu_a, fpu_b, fpu_sel, ea, eb, sel);
            end
            tick();
            n++;
        end
        checks++;
        if (n != LATENCY + 1) begin
            errors++;
            $display("FAIL %s latency: got %0d cycles exp %0d", tag, n, LATENCY + 1);
        end
        for (int h = 0; h < hold; h++) begin
            prev = result_o;
            tick();
            checks++;
            if (valid_o !== 1'b1 || ready_o !== 1'b0 || result_o !== prev) begin
                errors++;
                $display("FAIL %s backpressure: got valid=%0b ready=%0b res=%h exp 1/0/%h", tag, valid_o, ready_o, result_o, prev);
            end
        end
        ready_i = 1'b1;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard empty", tag);
        end else begin
            e = sb_q.pop_front();
            if (valid_o !== 1'b1 || result_o !== e.res || rd_o !== e.rd || wb_fp_o !== e.wb_fp) begin
                errors++;
                $display("FAIL %s result: got valid=%0b res=%h rd=%0d wb_fp=%0b exp 1 res=%h rd=%0d wb_fp=%0b",
                         tag, valid_o, result_o, rd_o, wb_fp_o, e.res, e.rd, e.wb_fp);
            end
        end
        tick();
        ready_i = 1'b0;
        checks++;
        if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
            errors++;
            $display("FAIL %s release: got valid=%0b ready=%0b exp 0/1", tag, valid_o, ready_o);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
        instr = '0; rs1_int = '0; frs1 = '0; frs2 = '0;
        tick(); tick();
        rst = 1'b0;
        checks++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0 || illegal_o !== 1'b0 || wb_fp_o !== 1'b0 ||
            fpu_sel !== 5'd0 || fpu_a !== 32'd0 || fpu_b !== 32'd0 || result_o !== 32'd0 || rd_o !== 5'd0) begin
            errors++;
            $display("FAIL reset: got ready=%0b valid=%0b ill=%0b wb=%0b sel=%0d a=%h b=%h res=%h rd=%0d exp 1,0,0,0,0,0,0,0,0",
                     ready_o, valid_o, illegal_o, wb_fp_o, fpu_sel, fpu_a, fpu_b, result_o, rd_o);
        end
    endtask

    task automatic test_fadd();
        run_op("fadd", mk(7'h00, 5'd2, 3'd0, 5'd3), 32'd0, 32'h3F800000, 32'h40000000, 0);
        checks++;
        if (result_o !== 32'h40400000) begin
            errors++;
            $display("FAIL fadd value: got %h exp 40400000", result_o);
        end
    endtask

    task automatic test_flt();
        run_op("flt", mk(7'h50, 5'd2, 3'd1, 5'd17), 32'd0, 32'h3F800000, 32'h40000000, 0);
    endtask

    task automatic test_fcvt();
        run_op("fcvt_s_w", mk(7'h68, 5'd0, 3'd0, 5'd9), 32'd5, 32'hDEADBEEF, 32'h12345678, 0);
        checks++;
        if (result_o !== 32'h40A00000) begin
            errors++;
            $display("FAIL fcvt value: got %h exp 40A00000", result_o);
        end
    endtask

    task automatic test_backpressure();
        run_op("fmul_bp", mk(7'h08, 5'd1, 3'd0, 5'd21), 32'd0, 32'h40490FDB, 32'hC0000000, 4);
    endtask

    task automatic test_illegal();
        run_op("fsqrt", mk(7'h2C, 5'd0, 3'd0, 5'd4), 32'd0, 32'h1, 32'h2, 0);
        run_op("bad_opcode", {7'h00, 5'd2, 5'd3, 3'd0, 5'd4, 7'b0110011}, 32'd0, 32'h1, 32'h2, 0);
        run_op("fcvt_rs2", mk(7'h68, 5'd1, 3'd0, 5'd4), 32'd7, 32'h1, 32'h2, 0);
        run_op("fmin_rm", mk(7'h14, 5'd2, 3'd2, 5'd4), 32'd0, 32'h1, 32'h2, 0);
        run_op("fcmp_rm", mk(7'h50, 5'd2, 3'd3, 5'd4), 32'd0, 32'h1, 32'h2, 0);
        run_op("fmv_x_rm", mk(7'h70, 5'd0, 3'd1, 5'd4), 32'd0, 32'h1, 32'h2, 0);
    endtask

    task automatic test_flush();
        int n;
        instr = mk(7'h08, 5'd2, 3'd0, 5'd5); frs1 = 32'h11; frs2 = 32'h22; valid_i = 1'b1;
        tick();
        valid_i = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
            errors++;
            $display("FAIL flush exec: got ready=%0b valid=%0b exp 1/0", ready_o, valid_o);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (valid_o !== 1'b0) begin
                errors++;
                $display("FAIL flush no result: got valid=%0b exp 0", valid_o);
            end
        end
        instr = mk(7'h04, 5'd2, 3'd0, 5'd6); valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        n = 0;
        while (!valid_o && n < 20) begin tick(); n++; end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0 || n >= 20) begin
            errors++;
            $display("FAIL flush done: got ready=%0b valid=%0b wait=%0d exp 1/0 wait<20", ready_o, valid_o, n);
        end
        instr = mk(7'h00, 5'd2, 3'd0, 5'd7); valid_i = 1'b1; flush = 1'b1;
        tick();
        valid_i = 1'b0; flush = 1'b0;
        checks++;
        if (ready_o !== 1'b1 || illegal_o !== 1'b0) begin
            errors++;
            $display("FAIL flush wins: got ready=%0b ill=%0b exp 1/0", ready_o, illegal_o);
        end
        instr = mk(7'h2C, 5'd0, 3'd0, 5'd7); valid_i = 1'b1; flush = 1'b1;
        tick();
        valid_i = 1'b0; flush = 1'b0;
        checks++;
        if (illegal_o !== 1'b0) begin
            errors++;
            $display("FAIL flush illegal: got ill=%0b exp 0", illegal_o);
        end
        instr = mk(7'h00, 5'd2, 3'd0, 5'd8); valid_i = 1'b1;
        tick();
        valid_i = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
            errors++;
            $display("FAIL reset exec: got ready=%0b valid=%0b exp 1/0", ready_o, valid_o);
        end
    endtask

    function automatic logic [31:0] pick(input int k, input logic [4:0] rd);
        case (k)
            0:  return mk(7'h00, 5'd2, 3'd7, rd);
            1:  return mk(7'h04, 5'd2, 3'd0, rd);
            2:  return mk(7'h08, 5'd2, 3'd1, rd);
            3:  return mk(7'h14, 5'd2, 3'd0, rd);
            4:  return mk(7'h14, 5'd2, 3'd1, rd);
            5:  return mk(7'h50, 5'd2, 3'd2, rd);
            6:  return mk(7'h50, 5'd2, 3'd1, rd);
            7:  return mk(7'h50, 5'd2, 3'd0, rd);
            8:  return mk(7'h70, 5'd0, 3'd0, rd);
            9:  return mk(7'h78, 5'd0, 3'd0, rd);
            10: return mk(7'h68, 5'd0, 3'd0, rd);
            default: return mk(7'h60, 5'd0, 3'd1, rd);
        endcase
    endfunction

    task automatic test_back_to_back();
        for (int k = 0; k < 24; k++) begin
            run_op("b2b", pick(k % 12, 5'($urandom_range(0, 31))), $urandom(), $urandom(), $urandom(),
                   int'($urandom_range(0, 2)));
        end
    endtask

    task automatic test_sgnj();
        run_op("fsgnjn", mk(7'h10, 5'd2, 3'd1, 5'd12), 32'd0, 32'h3F800000, 32'h3F800000, 0);
`ifdef FPU_SGNJ_EN
        checks++;
        if (result_o !== 32'hBF800000) begin
            errors++;
            $display("FAIL fsgnjn value: got %h exp BF800000", result_o);
        end
        run_op("fsgnj", mk(7'h10, 5'd2, 3'd0, 5'd13), 32'd0, 32'h3F800000, 32'hC0000000, 0);
        run_op("fsgnjx", mk(7'h10, 5'd2, 3'd2, 5'd14), 32'd0, 32'hBF800000, 32'hC0000000, 0);
        run_op("fsgnj_rm3", mk(7'h10, 5'd2, 3'd3, 5'd14), 32'd0, 32'h1, 32'h2, 0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fadd();
        test_flt();
        test_fcvt();
        test_backpressure();
        test_illegal();
        test_flush();
        test_back_to_back();
        test_sgnj();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard leftover: got %0d entries exp 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
